// File: rtl/rr_arb_pry.sv
// Round-robin arbiter: rotating-mask rightmost-priority pick,
// registered one-hot grant held until accepted downstream.
module rr_arb_pry #(
  parameter int WIDTH = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic                 ena,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld,
  input  logic                 rdy
);

  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     nmask;
  logic [WIDTH-1:0]     m_eff;
  logic [WIDTH-1:0]     mr;
  logic [WIDTH-1:0]     pick;
  logic [WIDTH-1:0]     sel;
  logic [WIDTH_LOG-1:0] sel_idx;
  logic                 xfer;
  logic                 load;

  assign xfer = vld & rdy;
  assign load = ena & (|req) & (~vld | xfer);

  // next pointer: everything strictly above the granted index
  always_comb begin
    nmask = '0;
    for (int i = 0; i < WIDTH; i++)
      nmask[i] = (WIDTH_LOG'(i) > idx);
  end

  assign m_eff = xfer ? nmask : mask;
  assign mr    = req & m_eff;
  assign pick  = (|mr) ? mr : req;
  assign sel   = pick & (~pick + WIDTH'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (sel[i]) sel_idx = WIDTH_LOG'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
      gnt  <= '0;
      idx  <= '0;
      vld  <= 1'b0;
    end else begin
      if (xfer) mask <= nmask;
      if (load) begin
        gnt <= sel;
        idx <= sel_idx;
        vld <= 1'b1;
      end else if (xfer) begin
        gnt <= '0;
        idx <= '0;
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_arb_pry.md
# rr_arb_pry

Round-robin arbiter that turns a raw request vector into a registered, held one-hot grant with a valid/ready handshake. It sits directly upstream of the consumers of priority/one-hot selection. Requests are first masked by a rotating priority pointer. A rightmost-priority (lowest index wins) selection runs over the masked vector, with fallback to the unmasked vector. The winner is then latched until the downstream stage accepts it. The result is fairness across `WIDTH` requesters, with the same rightmost-priority semantics used throughout the library.

## Interface
- `WIDTH`, 32: number of requesters; any value ≥ 2.
- `WIDTH_LOG`, `$clog2(WIDTH)`: local; binary index width.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  `WIDTH`  request vector, bit i = requester i.
- `ena`  input  1  enable; 0 blocks loading of a new grant (a held grant is unaffected).
- `gnt`  output  `WIDTH`  registered one-hot grant; all zero when `vld`=0.
- `idx`  output  `WIDTH_LOG`  binary index of the set bit of `gnt`; 0 when `vld`=0.
- `vld`  output  1  grant valid.
- `rdy`  input  1  downstream accepts grant; transfer = `vld & rdy`.

## Operation
- State registers:
  - `mask` [`WIDTH`]: priority pointer.
  - `gnt`, `idx`, `vld`: grant register.
- Two states, derived from `vld`:
  - IDLE (`vld`=0).
  - HOLD (`vld`=1).
- Selection function `sel(m)`:
  - `mr = req & m`.
  - If `mr` != 0: one-hot of the rightmost set bit of `mr`.
  - Else: one-hot of the rightmost set bit of `req`.
  - If `req` = 0: result zero.
- Effective mask `m_eff`:
  - On a transfer cycle, it is the next pointer derived from the current `gnt`: bits i+1..WIDTH-1 set, where i = `idx`.
  - Otherwise it is the `mask` register.
  - If i = WIDTH-1, `m_eff` = all zero, so the fallback picks the rightmost raw request.
- IDLE: if `ena` and `req` != 0:
  - Load `gnt` = `sel(m_eff)`, `idx` = its index, `vld` = 1.
  - Go to HOLD.
  - Otherwise stay in IDLE with outputs zero.
- HOLD: `gnt`/`idx` are held stable regardless of `req` changes, including withdrawal of the granted request (sticky grant).
- HOLD with transfer:
  - `mask` <= next pointer from the current `idx`.
  - If `ena` and `req` != 0: load a new grant `sel(m_eff)` in the same edge (back-to-back), stay in HOLD.
  - Otherwise `vld` <= 0, `gnt` <= 0, `idx` <= 0, go to IDLE.
- HOLD without transfer: no state change. `ena`=0 does not drop a held grant.
- A requester holding `req` continuously is re-granted only after every other active requester at a higher index, then wrapped lower indices, has been served. If it is the sole requester it is re-granted back-to-back.
- `mask` is updated only on transfer. IDLE loads use the stored `mask`.

## Timing
- Reset (async assert, any time, including mid-HOLD):
  - `gnt` = 0, `idx` = 0, `vld` = 0, `mask` = all ones.
  - Deassertion is synchronous to `clk`; the first grant can load on the first edge after release.
- Latency: a request present at edge N with `ena`=1 in IDLE gives `vld`=1 after edge N (1 cycle).
- Throughput: one grant per cycle when `rdy`=1 continuously and requests are present.
- Output stability: once `vld`=1, `gnt`/`idx` may change only on the edge following a transfer.
- `rdy` while `vld`=0: ignored, no effect.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `idx` is consistent with `gnt`.
  - `vld` == (`gnt` != 0).

## Test plan
All cases use WIDTH=4.
1. Reset, then `req`=4'b1010, `ena`=1, `rdy`=1 held → grants `gnt`=0010, 1000, 0010, 1000… on consecutive cycles; `idx`=1,3,1,3.
2. `req`=4'b1111, `rdy`=1 continuous → `gnt` rotates 0001, 0010, 0100, 1000, 0001; `vld` stays 1 with no bubbles.
3. `req`=4'b0100, `rdy`=0 for 5 cycles, `req` dropped to 0 at cycle 2 → `gnt`=0100 stable all 5 cycles. Raise `rdy` → one transfer, then `vld`=0, `gnt`=0, `mask`=1000.
4. After a grant at bit 3 transfers with `req`=4'b1001 → next `gnt`=0001 (wrap via empty mask); following grant `gnt`=1000.
5. `ena`=0 with `req`=4'b0011 in IDLE → `vld` stays 0. Set `ena`=1 → `gnt`=0001 one cycle later. Set `ena`=0 in HOLD → grant held; transfer then leaves `vld`=0.
6. Assert `rst_n`=0 mid-HOLD between clock edges → outputs clear immediately without a clock. After release with `req`=4'b1000 → `gnt`=1000 one cycle later (mask reset to all ones).
